ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_unit_fifo.sv | 65 ++++++
 rtl/ifetch_unit.sv | 91 +++++++++
 tb/tb_ifetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, fetch-entry payload and PC alignment helper for the fetch unit.
package ifetch_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 2;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Two-entry instruction buffer with synchronous flush and simultaneous push/pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     mem_q [2];
    logic             rd_q;
    logic             wr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        do_pop  = 1'b0;
        do_push = 1'b0;
        count_d = count_q;
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers; flush empties the buffer at the edge.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues sequential word reads, buffers responses, handles redirects.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic             inflight_q;
    logic [PC_W-1:0]  inflight_pc_q;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push;
    logic             flush;
    logic             issue;
    logic [2:0]       occupancy;

    // Issue decision, response push qualification and next-PC selection.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        issue      = 1'b0;
        occupancy  = '0;
        pc_d       = pc_q;
        push_entry = '0;

        pop        = out_valid && out_ready;
        flush      = reset || redirect_valid;
        push       = inflight_q && !flush;
        push_entry = '{pc: inflight_pc_q, instr: imem_data};
        // Buffered plus in-flight must stay below depth once this cycle's pop leaves.
        occupancy  = 3'(fifo_count) + 3'(inflight_q);
        issue      = !reset && !redirect_valid &&
                     (occupancy < (3'(FIFO_DEPTH) + 3'(pop)));

        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d = pc_q + PC_W'(4);
        end
    end

    // PC and in-flight tracking; a dropped issue leaves inflight clear so its data is never pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= align_pc(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= issue;
            inflight_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign out_valid = (fifo_count != '0) && !reset;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit with a word-indexed memory model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        en;
        logic [15:0] addr;
        logic        ov;
        logic [15:0] opc;
        logic [31:0] oin;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    ifetch_unit #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return 32'h1000_0000 + 32'(a[15:2]);
    endfunction

    // Memory returns word_at(addr) one cycle after a read strobe.
    initial imem_data = '0;
    always @(posedge clk) begin
        if (imem_en) imem_data <= word_at(imem_addr);
    end

    function automatic vec_t mk(input logic rst, input logic rv, input logic [15:0] rpc,
                                input logic rdy, input logic en, input logic [15:0] addr,
                                input logic ov, input logic [15:0] opc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.en = en; v.addr = addr; v.ov = ov; v.opc = opc; v.oin = word_at(opc);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [15:0] rpc, input logic rdy);
        reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int          hs;
    logic [15:0] exp_pc;

    initial begin
        //            rst rv  rpc       rdy en  addr      ov  opc
        tbl[0]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000);
        tbl[3]  = mk(0, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0000);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 1, 16'h000C, 1, 16'h0004);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0010, 1, 16'h0008);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0010, 1, 16'h0008);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0010, 1, 16'h0008);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0010, 1, 16'h0008);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0010, 1, 16'h0008);
        tbl[10] = mk(0, 0, 16'h0000, 1, 1, 16'h0010, 1, 16'h0008);
        tbl[11] = mk(0, 0, 16'h0000, 1, 1, 16'h0014, 1, 16'h000C);
        tbl[12] = mk(0, 0, 16'h0000, 1, 1, 16'h0018, 1, 16'h0010);
        tbl[13] = mk(0, 1, 16'h0043, 1, 0, 16'h001C, 1, 16'h0014);
        tbl[14] = mk(0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000);
        tbl[15] = mk(0, 0, 16'h0000, 1, 1, 16'h0044, 0, 16'h0000);
        tbl[16] = mk(0, 0, 16'h0000, 1, 1, 16'h0048, 1, 16'h0040);
        tbl[17] = mk(0, 1, 16'h0100, 1, 0, 16'h004C, 1, 16'h0044);
        tbl[18] = mk(0, 1, 16'h0200, 1, 0, 16'h0100, 0, 16'h0000);
        tbl[19] = mk(0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000);
        tbl[20] = mk(0, 0, 16'h0000, 1, 1, 16'h0204, 0, 16'h0000);
        tbl[21] = mk(0, 0, 16'h0000, 1, 1, 16'h0208, 1, 16'h0200);
        tbl[22] = mk(0, 1, 16'hFFF8, 1, 0, 16'h020C, 1, 16'h0204);
        tbl[23] = mk(0, 0, 16'h0000, 1, 1, 16'hFFF8, 0, 16'h0000);
        tbl[24] = mk(0, 0, 16'h0000, 1, 1, 16'hFFFC, 0, 16'h0000);
        tbl[25] = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'hFFF8);
        tbl[26] = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'hFFFC);
        tbl[27] = mk(0, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0000);
        tbl[28] = mk(0, 0, 16'h0000, 1, 1, 16'h000C, 1, 16'h0004);
        tbl[29] = mk(1, 0, 16'h0000, 0, 0, 16'h0010, 0, 16'h0000);
        tbl[30] = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000);
        tbl[31] = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000);
        tbl[32] = mk(0, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0000);

        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        next_cycle();
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            #2;
            chk("imem_en", i, 32'(imem_en), 32'(tbl[i].en));
            chk("imem_addr", i, 32'(imem_addr), 32'(tbl[i].addr));
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk("out_pc", i, 32'(out_pc), 32'(tbl[i].opc));
                chk("out_instr", i, out_instr, tbl[i].oin);
            end
            next_cycle();
        end

        // Random backpressure: delivered stream must stay in order with no loss or duplication.
        exp_pc = 16'h0004;
        hs = 0;
        for (int c = 0; c < 60; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'($urandom_range(0, 1)));
            #2;
            if (out_valid) begin
                chk("stream_pc", 100 + c, 32'(out_pc), 32'(exp_pc));
                chk("stream_instr", 100 + c, out_instr, word_at(exp_pc));
                if (out_ready) begin
                    exp_pc = exp_pc + 16'd4;
                    hs++;
                end
            end
            next_cycle();
        end
        checks++;
        if (hs < 5) begin
            errors++;
            $display("FAIL stream_progress: got %0d handshakes expected at least 5", hs);
        end

        // Fill the buffer under stall, then a single reset cycle must drop everything.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #2;
        chk("full_no_issue", 200, 32'(imem_en), 32'd0);
        chk("full_valid", 200, 32'(out_valid), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        #2;
        chk("post_reset_valid", 201, 32'(out_valid), 32'd0);
        chk("post_reset_en", 201, 32'(imem_en), 32'd1);
        chk("post_reset_addr", 201, 32'(imem_addr), 32'h0000);
        next_cycle();
        next_cycle();
        #2;
        chk("post_reset_pc", 202, 32'(out_pc), 32'h0000);
        chk("post_reset_out_valid", 202, 32'(out_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
